// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared types for the sequential ALU.
//   alu_op_t    - 3-bit operation codes presented on the op input.
//   alu_state_t - control states of the top-level sequencer.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_HOLD = 2'b10
    } alu_state_t;

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: operand/result handshake bundle of seq_alu.
//   Input side : in_valid, in_ready, op, a, b
//   Output side: out_valid, out_ready, result, result_hi, cout, ovf, zero, neg
//   master - operand source / result consumer; slave - the ALU.
interface seq_alu_if
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    alu_op_t          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, result_hi, cout, ovf, zero, neg
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, result_hi, cout, ovf, zero, neg
    );

endinterface

// File: rtl/seq_alu_mul.sv
// seq_alu_mul: unsigned shift-add multiplier, one partial product per cycle.
//   clk, rst_n - clock and asynchronous active-low reset
//   start      - latch a/b, clear accumulator and step counter
//   a, b       - multiplicand and multiplier
//   busy       - multiply in progress
//   done       - high during the cycle in which the final step is applied
//   product    - accumulator including the current step; full a*b while done
module seq_alu_mul
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [WIDTH-1:0]   mplier_r;
    logic [CW-1:0]      cnt_r;
    logic               busy_r;
    logic               last_s;

    // Partial-product add for the current step; exposing it lets the final
    // step and the result load share one edge.
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Final step is the one taken with the counter at WIDTH-1.
    always_comb begin
        last_s = 1'b0;
        if (busy_r && (cnt_r == CW'(WIDTH - 1))) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Operand latch on start, then one shift-add step per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= {(2*WIDTH){1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b0;
        end else if (start) begin
            mcand_r  <= {{WIDTH{1'b0}}, a};
            acc_r    <= {(2*WIDTH){1'b0}};
            mplier_r <= b;
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            acc_r    <= acc_next_s;
            mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            cnt_r    <= cnt_r + CW'(1);
            if (last_s) begin
                busy_r <= 1'b0;
            end
        end
    end

    assign busy    = busy_r;
    assign done    = last_s;
    assign product = acc_next_s;

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshake on both sides.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - seq_alu_if slave: operands/op in, result/result_hi/flags out
// Single-cycle ops load the result register on the accept edge; MUL runs
// WIDTH shift-add steps in seq_alu_mul and loads on the final step.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    seq_alu_if.slave bus
);

    localparam logic [WIDTH:0] SHL_LIM = (WIDTH+1)'(WIDTH);

    alu_state_t         state_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   result_r;
    logic [WIDTH-1:0]   result_hi_r;
    logic               cout_r;
    logic               ovf_r;
    logic               zero_r;
    logic               neg_r;

    logic               in_ready_s;
    logic               accept_s;
    logic               start_mul_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH-1:0]   res_s;
    logic               cout_s;
    logic               ovf_s;
    logic               mul_busy_s;
    logic               mul_done_s;
    logic [2*WIDTH-1:0] mul_product_s;

    // Ready in IDLE, or in HOLD when the held result leaves this cycle.
    always_comb begin
        in_ready_s = 1'b0;
        if (state_r == ST_IDLE) begin
            in_ready_s = 1'b1;
        end else if (state_r == ST_HOLD) begin
            in_ready_s = bus.out_ready;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign accept_s    = bus.in_valid && in_ready_s;
    assign start_mul_s = accept_s && (bus.op == OP_MUL);

    // Single-cycle datapath; SUB reuses the adder as a + ~b + 1.
    always_comb begin
        sum_s  = {(WIDTH+1){1'b0}};
        res_s  = {WIDTH{1'b0}};
        cout_s = 1'b0;
        ovf_s  = 1'b0;
        case (bus.op)
            OP_ADD: begin
                sum_s  = {1'b0, bus.a} + {1'b0, bus.b};
                res_s  = sum_s[WIDTH-1:0];
                cout_s = sum_s[WIDTH];
                ovf_s  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                         (sum_s[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                sum_s  = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
                res_s  = sum_s[WIDTH-1:0];
                cout_s = sum_s[WIDTH];
                ovf_s  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                         (sum_s[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND: res_s = bus.a & bus.b;
            OP_OR:  res_s = bus.a | bus.b;
            OP_XOR: res_s = bus.a ^ bus.b;
            OP_SLT: res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SHL: begin
                if ({1'b0, bus.b} >= SHL_LIM) begin
                    res_s = {WIDTH{1'b0}};
                end else begin
                    res_s = bus.a << bus.b;
                end
            end
            OP_MUL:  res_s = {WIDTH{1'b0}};
            default: res_s = {WIDTH{1'b0}};
        endcase
    end

    seq_alu_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_mul_s),
        .a       (bus.a),
        .b       (bus.b),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // Control FSM with registered result, product high half and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            result_hi_r <= {WIDTH{1'b0}};
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            zero_r      <= 1'b0;
            neg_r       <= 1'b0;
        end else if (accept_s) begin
            if (start_mul_s) begin
                state_r     <= ST_MUL;
                out_valid_r <= 1'b0;
            end else begin
                state_r     <= ST_HOLD;
                out_valid_r <= 1'b1;
                result_r    <= res_s;
                result_hi_r <= {WIDTH{1'b0}};
                cout_r      <= cout_s;
                ovf_r       <= ovf_s;
                zero_r      <= (res_s == {WIDTH{1'b0}});
                neg_r       <= res_s[WIDTH-1];
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_MUL: begin
                    if (mul_done_s) begin
                        state_r     <= ST_HOLD;
                        out_valid_r <= 1'b1;
                        result_r    <= mul_product_s[WIDTH-1:0];
                        result_hi_r <= mul_product_s[2*WIDTH-1:WIDTH];
                        cout_r      <= 1'b0;
                        ovf_r       <= 1'b0;
                        zero_r      <= (mul_product_s == {(2*WIDTH){1'b0}});
                        neg_r       <= mul_product_s[2*WIDTH-1];
                    end else if (!mul_busy_s) begin
                        // Multiplier idle without finishing: recover to IDLE.
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.result_hi = result_hi_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
    assign bus.zero      = zero_r;
    assign bus.neg       = neg_r;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and randomized checks of seq_alu (WIDTH=4) against an
// arithmetic reference model.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic clk;
    logic rst_n;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Expected values of the transaction currently held at the output.
    int exp_r, exp_hi, exp_c, exp_v, exp_z, exp_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model from the arithmetic definition of each op.
    task automatic model(input int op, input int a, input int b,
                         output int r, output int hi, output int c,
                         output int v, output int z, output int n);
        int sa, sb, s, p;
        sa = (a >= M/2) ? a - M : a;
        sb = (b >= M/2) ? b - M : b;
        r = 0; hi = 0; c = 0; v = 0; p = 0; s = 0;
        case (op)
            0: begin s = a + b; r = s % M; c = (s >= M); v = ((sa+sb) > (M/2-1)) || ((sa+sb) < -(M/2)); end
            1: begin r = (a - b + M) % M; c = (a >= b); v = ((sa-sb) > (M/2-1)) || ((sa-sb) < -(M/2)); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (sa < sb) ? 1 : 0;
            6: r = (b >= W) ? 0 : ((a << b) % M);
            7: begin p = a * b; r = p % M; hi = p / M; end
            default: r = 0;
        endcase
        z = (r == 0 && hi == 0) ? 1 : 0;
        n = (op == 7) ? ((hi >= M/2) ? 1 : 0) : ((r >= M/2) ? 1 : 0);
    endtask

    // Present one op, check latency and in_ready, then check the result.
    // Leaves the result held with out_ready low.
    task automatic send(input int op, input int a, input int b);
        int lat;
        lat = (op == 7) ? W + 1 : 1;
        model(op, a, b, exp_r, exp_hi, exp_c, exp_v, exp_z, exp_n);
        bus.out_ready = 1'b0;
        bus.op        = alu_op_t'(op[2:0]);
        bus.a         = a[W-1:0];
        bus.b         = b[W-1:0];
        bus.in_valid  = 1'b1;
        #1;
        chk("accept_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        for (int k = 1; k < lat; k++) begin
            chk("mul_valid_low", bus.out_valid, 0);
            chk("mul_ready_low", bus.in_ready, 0);
            step();
        end
        chk("latency_valid", bus.out_valid, 1);
        chk("result", bus.result, exp_r);
        chk("result_hi", bus.result_hi, exp_hi);
        chk("cout", bus.cout, exp_c);
        chk("ovf", bus.ovf, exp_v);
        chk("zero", bus.zero, exp_z);
        chk("neg", bus.neg, exp_n);
    endtask

    // Stall with junk operands offered, then consume the held result.
    task automatic drain(input int stall);
        for (int k = 0; k < stall; k++) begin
            bus.in_valid = 1'b1;
            bus.op       = alu_op_t'($urandom_range(0, 7));
            bus.a        = W'($urandom);
            bus.b        = W'($urandom);
            #1;
            chk("stall_ready", bus.in_ready, 0);
            step();
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_result", bus.result, exp_r);
            chk("stall_hi", bus.result_hi, exp_hi);
            chk("stall_flags", {bus.cout, bus.ovf, bus.zero, bus.neg},
                {exp_c[0], exp_v[0], exp_z[0], exp_n[0]});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("drain_valid", bus.out_valid, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {bus.out_valid, bus.result, bus.result_hi,
                  bus.cout, bus.ovf, bus.zero, bus.neg}, 0);
    endtask

    initial begin
        int op, a, b, r, hi, c, v, z, n;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = OP_ADD;
        bus.a         = '0;
        bus.b         = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_outputs");
        #2 rst_n = 1'b1;
        chk("reset_in_ready", bus.in_ready, 1);
        step();

        // Directed cases
        send(0, 9, 1);
        chk("add_9_1", {bus.result, bus.cout, bus.ovf, bus.neg, bus.zero}, {4'b1010, 4'b0010});
        drain(0);
        send(1, 9, 1);
        chk("sub_9_1", {bus.result, bus.cout, bus.ovf, bus.neg}, {4'b1000, 3'b101});
        drain(0);
        send(1, 1, 2);
        chk("sub_1_2", {bus.result, bus.cout}, {4'b1111, 1'b0});
        drain(0);
        send(0, 7, 1);
        chk("add_ovf", {bus.result, bus.ovf}, {4'b1000, 1'b1});
        drain(0);
        send(0, 15, 1);
        chk("add_wrap", {bus.result, bus.cout, bus.zero}, {4'b0000, 2'b11});
        drain(0);
        send(6, 3, 5);
        chk("shl_big", bus.result, 4'b0000);
        drain(0);
        send(5, 8, 7);
        chk("slt_neg", bus.result, 4'b0001);
        drain(0);
        send(7, 15, 15);
        chk("mul_ff", {bus.result_hi, bus.result, bus.zero, bus.neg}, {4'b1110, 4'b0001, 2'b01});
        drain(1);

        // Backpressure then same-cycle handover to a new op
        send(0, 2, 3);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_result", bus.result, 4'b0101);
            chk("bp_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = OP_AND;
        bus.a         = 4'b1100;
        bus.b         = 4'b1010;
        #1;
        chk("bp_handover_ready", bus.in_ready, 1);
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("bp_and_valid", bus.out_valid, 1);
        chk("bp_and_result", bus.result, 4'b1000);
        exp_r = 8; exp_hi = 0; exp_c = 0; exp_v = 0; exp_z = 0; exp_n = 1;
        drain(2);

        // Back-to-back single-cycle ops with out_ready held high
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = $urandom_range(0, 6);
            a  = $urandom_range(0, M-1);
            b  = $urandom_range(0, M-1);
            model(op, a, b, r, hi, c, v, z, n);
            bus.op       = alu_op_t'(op[2:0]);
            bus.a        = a[W-1:0];
            bus.b        = b[W-1:0];
            bus.in_valid = 1'b1;
            #1;
            chk("b2b_ready", bus.in_ready, 1);
            step();
            chk("b2b_valid", bus.out_valid, 1);
            chk("b2b_result", {bus.result, bus.cout, bus.ovf, bus.zero, bus.neg},
                {r[W-1:0], c[0], v[0], z[0], n[0]});
        end
        bus.in_valid = 1'b0;
        step();
        chk("b2b_idle", bus.out_valid, 0);
        bus.out_ready = 1'b0;

        // Reset two cycles into a multiply
        bus.op       = OP_MUL;
        bus.a        = 4'b1111;
        bus.b        = 4'b1111;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midmul_reset_outputs");
        chk("midmul_reset_idle", bus.in_ready, 1);
        #2 rst_n = 1'b1;
        chk("midmul_release_ready", bus.in_ready, 1);
        step();
        send(0, 1, 1);
        chk("post_reset_add", {bus.result, bus.result_hi}, {4'b0010, 4'b0000});
        drain(0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("no_stale_product", bus.out_valid, 0);
        end

        // Randomized transactions with random stalls
        for (int i = 0; i < 120; i++) begin
            send($urandom_range(0, 7), $urandom_range(0, M-1), $urandom_range(0, M-1));
            drain($urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU that succeeds the 4-bit combinational lab ALU. It adds a valid/ready handshake on both sides, registered status flags, a barrel shift, signed compare and a multi-cycle unsigned shift-add multiplier. It sits between an operand source (register file or test driver) and a result consumer, and holds one result at a time.

## Interface
- `WIDTH`, default 4: operand and result width; legal range 2..32.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands and op presented.
- `in_ready`  out  1  block can accept operands this cycle.
- `op`  in  3  operation select; codes in `seq_alu_pkg`.
- `a`, `b`  in  WIDTH  operands.
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  consumer takes the result this cycle.
- `result`  out  WIDTH  result, or low half of the product for MUL.
- `result_hi`  out  WIDTH  high half of the product for MUL; 0 for every other op.
- `cout`, `ovf`, `zero`, `neg`  out  1 each  status flags.

## Operation
- Opcodes:
  - 000 ADD: a+b.
  - 001 SUB: a-b, computed as a+~b+1.
  - 010 AND, 011 OR, 100 XOR.
  - 101 SLT: result = 1 if $signed(a) < $signed(b), else 0.
  - 110 SHL: a << b; b is an unsigned amount; an amount >= WIDTH gives 0.
  - 111 MUL: unsigned {result_hi,result} = a*b.
- Flags:
  - cout: carry out of the WIDTH-bit adder for ADD/SUB (SUB: 1 = no borrow); 0 for every other op.
  - ovf: signed overflow for ADD/SUB only; 0 otherwise.
  - zero: set when result is 0; for MUL, set only when both halves are 0.
  - neg: MSB of result; for MUL, MSB of result_hi.
- FSM states:
  - IDLE: accepting operands.
  - MUL: iterating the multiply.
  - HOLD: result valid, waiting for out_ready.
- Transfer: a transfer happens on a rising edge where in_valid and in_ready are both high.
- in_ready = (state==IDLE) or (state==HOLD and out_ready).
- Single-cycle op accepted: the result register loads it and the state goes to HOLD.
- MUL accepted: operands are latched, the accumulator and counter are cleared, and the state goes to MUL.
- In MUL: one shift-add step per cycle for WIDTH cycles, then HOLD.
- In HOLD with out_ready: a new transfer in the same cycle loads back-to-back. Without one, the state returns to IDLE and out_valid drops.
- Operands that change while in_ready is low are ignored.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE; in_ready reads 1 as soon as rst_n is released.
  - out_valid 0; result, result_hi, cout, ovf and neg are 0; zero is 0.
- Reset asserted mid-MUL aborts the multiply, discards its partial result and produces no output.
- Latency, measured from the accept edge to the edge that sets out_valid:
  - Single-cycle ops: 1 cycle.
  - MUL: WIDTH+1 cycles.
- Throughput:
  - Single-cycle ops: 1 per cycle with out_ready held high.
  - MUL: 1 per WIDTH+1 cycles.
- Backpressure: while out_valid=1 and out_ready=0, result, result_hi and all flags hold stable and in_ready=0.
- out_valid never drops without a transfer, except on reset.
- Undefined op values cannot occur; all 8 codes are defined.

## Structure
- `seq_alu_pkg` holds:
  - the `alu_op_t` enum (3 bits, codes as above);
  - the `alu_state_t` enum (IDLE, MUL, HOLD).
- One sub-module, `seq_alu_mul`: a WIDTH-parameterised shift-add multiplier.
  - Inputs: start, a, b.
  - Outputs: busy, done, a 2*WIDTH product.
  - The top level owns the FSM, the handshake, the single-cycle datapath and the flag logic.

## Test plan
All scenarios use WIDTH=4.
- ADD 1001+0001 -> result 1010, cout 0, ovf 0, neg 1, zero 0; out_valid one cycle after accept.
- SUB 1001-0001 -> result 1000, cout 1, ovf 0, neg 1. SUB 0001-0010 -> result 1111, cout 0.
- Boundaries:
  - ADD 0111+0001 -> result 1000, ovf 1.
  - ADD 1111+0001 -> result 0000, cout 1, zero 1.
  - SHL 0011 by 0101 -> result 0000.
  - SLT 1000,0111 -> result 0001.
- MUL 1111*1111 -> result_hi 1110, result 0001, zero 0, neg 1; out_valid exactly 5 cycles after accept; in_ready 0 throughout.
- Backpressure:
  - Hold out_ready low for 3 cycles after ADD 0010+0011: result stays 0101 and in_ready stays 0.
  - Then raise out_ready together with in_valid carrying AND 1100,1010: the next cycle shows result 1000.
- Deassert rst_n 2 cycles into a MUL:
  - all outputs go to 0 immediately and the state is IDLE;
  - after release, ADD 0001+0001 -> result 0010, and no stale product appears.
